// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with two bus-loaded operand registers.
// The add, sub, logic and inc ops finish in one cycle.
// The unsigned shift-add multiply and restoring divide take WIDTH iterations.
// Handshake: start is sampled only while IDLE.
// busy is high while a mul/div iterates, and done pulses for one cycle when
// result/result_hi/flags update. No backpressure exists, so an output is
// valid exactly in the done cycle and holds until the next done.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             ld_a,
   input  logic             ld_b,
   input  logic [2:0]       op,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic [3:0]       flags
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t state, state_next;

   logic [WIDTH-1:0] a, b;
   // Working copies taken at start, so operand loads during RUN do not disturb the op.
   logic [WIDTH-1:0] w_a, w_b;
   logic             w_div;
   // Shared iteration registers.
   // mul uses them as {hi, lo} of the product shift register.
   // div uses acc_hi as the remainder and acc_lo as the quotient/dividend.
   logic [WIDTH-1:0] acc_hi, acc_lo;
   logic [CW-1:0]    cnt;

   logic             is_multi;
   logic             last_iter;
   logic [WIDTH-1:0] sc_res;
   logic [3:0]       sc_flags;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi, mul_lo;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH-1:0] div_diff;
   logic             div_ge;
   logic [WIDTH-1:0] it_hi, it_lo;
   logic [3:0]       mc_flags;

   assign is_multi  = (op[2:1] == 2'b11);
   assign last_iter = (cnt == CW'(WIDTH - 1));

   // Next-state logic: only mul/div leave IDLE, and RUN exits after the last iteration.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start && is_multi) state_next = RUN;
         RUN:  if (last_iter) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Single-cycle op result and flags {divz, ovf, zero, neg} from the registered operands.
   always_comb begin
      sc_res   = '0;
      sc_flags = '0;
      case (op)
         3'b000: begin
            sc_res      = a + b;
            sc_flags[2] = (a[WIDTH-1] == b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
         end
         3'b001: begin
            sc_res      = a - b;
            sc_flags[2] = (a[WIDTH-1] != b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
         end
         3'b010: sc_res = a & b;
         3'b011: sc_res = a | b;
         3'b100: sc_res = a ^ b;
         3'b101: begin
            sc_res      = a + 1'b1;
            sc_flags[2] = (a == {1'b0, {(WIDTH-1){1'b1}}});
         end
         default: sc_res = '0;
      endcase
      sc_flags[1] = (sc_res == '0);
      sc_flags[0] = sc_res[WIDTH-1];
   end

   // One mul/div iteration.
   // mul adds the multiplicand when the product LSB is set, then shifts right.
   // div shifts in the next dividend bit and subtracts when the divisor fits.
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, w_a} : '0);
      mul_hi    = mul_sum[WIDTH:1];
      mul_lo    = {mul_sum[0], acc_lo[WIDTH-1:1]};
      div_shift = {acc_hi, acc_lo[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, w_b});
      div_diff  = div_shift[WIDTH-1:0] - w_b;
      if (w_div) begin
         it_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
         it_lo = {acc_lo[WIDTH-2:0], div_ge};
      end else begin
         it_hi = mul_hi;
         it_lo = mul_lo;
      end
      mc_flags[3] = w_div && (w_b == '0);
      mc_flags[2] = !w_div && (it_hi != '0);
      mc_flags[1] = (it_lo == '0) && (it_hi == '0);
      mc_flags[0] = it_lo[WIDTH-1];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Operand loads, op launch, iteration and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         a         <= '0;
         b         <= '0;
         w_a       <= '0;
         w_b       <= '0;
         w_div     <= 1'b0;
         acc_hi    <= '0;
         acc_lo    <= '0;
         cnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         result_hi <= '0;
         flags     <= '0;
      end else begin
         if (ld_a) a <= din;
         if (ld_b) b <= din;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (is_multi) begin
                     w_a    <= a;
                     w_b    <= b;
                     w_div  <= op[0];
                     acc_hi <= '0;
                     acc_lo <= op[0] ? a : b;
                     cnt    <= '0;
                     busy   <= 1'b1;
                  end else begin
                     result    <= sc_res;
                     result_hi <= '0;
                     flags     <= sc_flags;
                     done      <= 1'b1;
                  end
               end
            end
            RUN: begin
               acc_hi <= it_hi;
               acc_lo <= it_lo;
               cnt    <= cnt + 1'b1;
               if (last_iter) begin
                  result    <= it_lo;
                  result_hi <= it_hi;
                  flags     <= mc_flags;
                  done      <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: busy <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq at WIDTH = 8, with hand-computed expected values.
module tb_alu_seq;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] din = '0;
   logic         ld_a = 1'b0;
   logic         ld_b = 1'b0;
   logic [2:0]   op = '0;
   logic         start = 1'b0;
   logic         busy, done;
   logic [W-1:0] result, result_hi;
   logic [3:0]   flags;

   int n_checks = 0;
   int n_errors = 0;
   int lat, bcnt, dcnt;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .din(din), .ld_a(ld_a), .ld_b(ld_b), .op(op),
      .start(start), .busy(busy), .done(done), .result(result),
      .result_hi(result_hi), .flags(flags)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // All drivers start and end at #1 after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_ab(input logic [W-1:0] va, input logic [W-1:0] vb);
      din = va; ld_a = 1'b1; tick(); ld_a = 1'b0;
      din = vb; ld_b = 1'b1; tick(); ld_b = 1'b0;
   endtask

   // Pulse start for one edge, then wait (bounded) for done.
   // lat counts edges after the start edge, and bc counts the cycles with busy high.
   task automatic run_op(input logic [2:0] o, output int lt, output int bc);
      op = o; start = 1'b1; tick(); start = 1'b0;
      lt = 0; bc = 0;
      while (!done && lt < 40) begin
         if (busy) bc++;
         tick();
         lt++;
      end
      if (!done) check("done_timeout", 32'(lt), 32'(W));
   endtask

   // Check the outputs in the done cycle.
   task automatic expect_out(input string tag, input logic [W-1:0] r, input logic [W-1:0] rh,
                             input logic [3:0] f);
      check({tag, "_result"}, 32'(result), 32'(r));
      check({tag, "_result_hi"}, 32'(result_hi), 32'(rh));
      check({tag, "_flags"}, 32'(flags), 32'(f));
   endtask

   initial begin
      tick(); tick();
      rst = 1'b0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      expect_out("rst", 8'h00, 8'h00, 4'b0000);

      // add 100 + 50 signed-overflows into the sign bit
      load_ab(8'd100, 8'd50);
      run_op(3'b000, lat, bcnt);
      check("add_lat", 32'(lat), 32'd0);
      check("add_done", 32'(done), 32'd1);
      expect_out("add", 8'h96, 8'h00, 4'b0101);
      tick();
      check("add_done_pulse", 32'(done), 32'd0);
      check("add_hold", 32'(result), 32'h96);

      load_ab(8'd0, 8'd0);
      run_op(3'b000, lat, bcnt);
      expect_out("add0", 8'h00, 8'h00, 4'b0010);

      load_ab(8'd5, 8'd7);
      run_op(3'b001, lat, bcnt);
      expect_out("sub", 8'hFE, 8'h00, 4'b0001);

      load_ab(8'h7F, 8'h00);
      run_op(3'b101, lat, bcnt);
      expect_out("inc", 8'h80, 8'h00, 4'b0101);

      load_ab(8'hF0, 8'h3C);
      run_op(3'b010, lat, bcnt);
      expect_out("and", 8'h30, 8'h00, 4'b0000);
      run_op(3'b011, lat, bcnt);
      expect_out("or", 8'hFC, 8'h00, 4'b0001);
      run_op(3'b100, lat, bcnt);
      expect_out("xor", 8'hCC, 8'h00, 4'b0001);

      // mul 200 * 3 = 600 = 0x0258
      load_ab(8'd200, 8'd3);
      run_op(3'b110, lat, bcnt);
      check("mul_lat", 32'(lat), 32'(W));
      check("mul_busy_cycles", 32'(bcnt), 32'(W));
      check("mul_busy_at_done", 32'(busy), 32'd0);
      expect_out("mul", 8'h58, 8'h02, 4'b0100);
      tick();
      check("mul_done_pulse", 32'(done), 32'd0);

      load_ab(8'd0, 8'd255);
      run_op(3'b110, lat, bcnt);
      expect_out("mul0", 8'h00, 8'h00, 4'b0010);

      // div 200 / 7 = 28 r 4
      load_ab(8'd200, 8'd7);
      run_op(3'b111, lat, bcnt);
      check("div_lat", 32'(lat), 32'(W));
      check("div_busy_cycles", 32'(bcnt), 32'(W));
      expect_out("div", 8'd28, 8'd4, 4'b0000);

      load_ab(8'h2A, 8'h00);
      run_op(3'b111, lat, bcnt);
      check("divz_lat", 32'(lat), 32'(W));
      expect_out("divz", 8'hFF, 8'h2A, 4'b1001);

      // start pulsed at RUN cycle 3 of a mul is ignored
      load_ab(8'd13, 8'd11);
      op = 3'b110; start = 1'b1; tick(); start = 1'b0;
      dcnt = 0;
      for (int i = 1; i < 30; i++) begin
         if (i == 3) begin op = 3'b000; start = 1'b1; end
         else start = 1'b0;
         tick();
         if (done) begin
            dcnt++;
            if (dcnt == 1) expect_out("mul_ign", 8'h8F, 8'h00, 4'b0001);
         end
      end
      start = 1'b0;
      check("mul_ign_done_count", 32'(dcnt), 32'd1);

      // a load on the start edge affects only the next op
      load_ab(8'd1, 8'd2);
      din = 8'd9; ld_a = 1'b1;
      run_op(3'b000, lat, bcnt);
      ld_a = 1'b0;
      check("ld_same_edge", 32'(result), 32'd3);
      run_op(3'b000, lat, bcnt);
      check("ld_next_op", 32'(result), 32'd11);

      // reset at RUN cycle 4 aborts the op with no done
      load_ab(8'd200, 8'd3);
      op = 3'b110; start = 1'b1; tick(); start = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1; tick(); rst = 1'b0;
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_done", 32'(done), 32'd0);
      expect_out("rst_mid", 8'h00, 8'h00, 4'b0000);
      dcnt = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done) dcnt++;
      end
      check("rst_mid_no_done", 32'(dcnt), 32'd0);
      // A and B were cleared, so an add gives zero.
      run_op(3'b000, lat, bcnt);
      expect_out("rst_ab", 8'h00, 8'h00, 4'b0010);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU: the next generation of the board's 8-bit switch-loaded ALU. It holds two operand registers loaded from a shared data bus and runs single-cycle add/sub/logic/increment ops. It also runs multi-cycle unsigned shift-add multiply and restoring divide behind a start/busy/done handshake, and registers result and flag outputs for the display and LED path.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- din  in  WIDTH  operand data bus
- ld_a  in  1  load din into operand register A at the edge
- ld_b  in  1  load din into operand register B at the edge
- op  in  3  000 add, 001 sub (A−B), 010 and, 011 or, 100 xor, 101 inc (A+1), 110 mul, 111 div
- start  in  1  request operation; sampled only in IDLE
- busy  out  1  high while a mul/div is iterating
- done  out  1  one-cycle pulse when result/flags update
- result  out  WIDTH  primary result (mul low half, div quotient)
- result_hi  out  WIDTH  mul high half / div remainder; 0 for other ops
- flags  out  4  {divz, ovf, zero, neg}

## Operation
- The reset is synchronous and active-high on clk; the design uses one clock.
- Reset: A, B, result, result_hi, flags = 0; busy = 0; done = 0; state = IDLE. Reset mid-operation aborts and emits no done.
- ld_a/ld_b are honoured in any state, and both may be asserted together. An operation uses the A/B/op values registered before the start edge. A load on the same edge as start affects only the next op.
- States: IDLE, RUN.
- In IDLE with start = 1 and op in 000–101: compute, register result/flags, pulse done. The state stays IDLE.
- In IDLE with start = 1 and op 110/111: snapshot A, B and op into working registers, clear the iteration counter, go to RUN, and raise busy.
- RUN executes one iteration per cycle for WIDTH iterations, then writes the outputs, pulses done, drops busy and returns to IDLE.
- start in RUN is ignored; it is neither queued nor extended.
- mul: unsigned, 2·WIDTH product with shift-add, LSB first. result = low half, result_hi = high half.
- div: unsigned restoring, MSB first. result = quotient, result_hi = remainder. B = 0 runs the full length with no special case and yields quotient all-ones, remainder = A, and divz = 1.
- Width rules: add/sub/inc are WIDTH-bit modulo. Logic ops are bitwise.
- neg = result[WIDTH−1] for all ops.
- zero = (result == 0); for mul/div it also requires result_hi == 0.
- ovf is set as follows:
  - add: signed overflow (A, B same sign, result sign differs).
  - sub: A, B differ in sign and result sign ≠ A sign.
  - inc: A = 0111…1.
  - mul: result_hi ≠ 0.
  - logic and div: 0.
- divz = 1 only for div with B = 0.
- result, result_hi and flags hold their values until the next done.

## Timing
- Let edge k be the edge that samples start = 1 in IDLE.
- Single-cycle ops: outputs and done = 1 are valid in the cycle after edge k. Latency is 1.
- mul/div: edge k initialises and sets busy. Iterations run on edges k+1 … k+WIDTH. Outputs update and done = 1 after edge k+WIDTH, with busy = 0 in that cycle. busy is high for exactly WIDTH cycles. Latency is WIDTH.
- done is never high for two consecutive cycles from a single start.
- A new start may be sampled in the cycle done is high, because the state is IDLE. Back-to-back single-cycle ops give done every cycle.
- Outputs are fully registered; there is no combinational path from inputs to outputs.

## Test plan
- Add, WIDTH = 8: A = 100, B = 50, op 000, start → after 1 edge result = 0x96, done = 1 for one cycle, flags = {0,1,0,1}. Repeat with A = B = 0 → zero = 1, all other flags 0.
- Sub/inc: A = 5, B = 7, sub → result 0xFE, neg = 1, ovf = 0. A = 0x7F, inc → result 0x80, ovf = 1, neg = 1.
- Mul: A = 200, B = 3, op 110 → busy high 8 cycles, then result = 0x58, result_hi = 0x02, ovf = 1, done one cycle. 0×255 → zero = 1, ovf = 0.
- Div: A = 200, B = 7 → result = 28, result_hi = 4, done 8 cycles after start. A = 0x2A, B = 0 → result = 0xFF, result_hi = 0x2A, divz = 1, same latency.
- Handshake: start pulsed at RUN cycle 3 of a mul → ignored, exactly one done. ld_a = 1 with din = 9 on the same edge as start for an add → the add uses the old A, and A reads 9 on the next op.
- Reset: rst asserted at RUN cycle 4 → next cycle busy = 0, done = 0, result/result_hi/flags = 0, A = B = 0. No done pulse follows.
